rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Arbiter for the single register-file write port, shared between the WB stage and a long-latency divider writeback path. It buffers divider results in a 2-entry FIFO and gives WB priority. An aging counter forces a one-cycle WB hold when a divider result has waited too long. It also exports a pending-register mask so ID can stall readers and writers of a register whose divider result has not yet retired.

## Interface
Parameters:
- MAX_WAIT, 4, cycles a FIFO head may wait before WB is held (1..15)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb_valid  in  1  WB stage holds a valid instruction
- wb_rf_zip  in  38  {we, waddr[4:0], wdata[31:0]} from WB
- wb_hold  out  1  port granted to divider this cycle; WB ready_go must be low, WB keeps its contents
- div_valid  in  1  divider result offered
- div_ready  out  1  FIFO can accept (not full)
- div_waddr  in  5  divider destination register
- div_wdata  in  32  divider result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- div_pend_vec  out  32  bit i set while a FIFO entry targets register i
- perf_hold_cnt  out  32  count of wb_hold cycles
- perf_drop_cnt  out  32  count of dropped divider entries

## Operation
- FIFO has 2 entries: head/tail pointers and a 2-bit count.
- Enqueue when div_valid & div_ready. div_waddr==0 is accepted but not enqueued, so it is dropped silently.
- WB request: wb_req = wb_valid & we & (waddr!=0).
- Grant rules, evaluated each cycle:
  - FIFO non-empty and age==MAX_WAIT: grant the divider. wb_hold=1; rf_* = head entry; dequeue.
  - Else if wb_req: grant WB. rf_* = WB fields; age increments if FIFO non-empty, saturating at MAX_WAIT.
  - Else if FIFO non-empty: grant the divider. rf_* = head; dequeue; wb_hold=0.
  - Else: rf_we=0.
- Age resets to 0 on every dequeue and whenever the FIFO is empty.
- wb_hold is asserted only when wb_req=1 would otherwise have won. If WB is idle, the head simply writes with wb_hold=0.
- WAW conflict: a WB write whose waddr matches a FIFO entry invalidates that entry (WB is younger). The entry is removed at the clock edge and perf_drop_cnt increments. ID stalls on div_pend_vec, so this is an error-recovery path only.
- Simultaneous enqueue and dequeue with the FIFO full: div_ready is based on the registered count, so no enqueue occurs that cycle.
- div_pend_vec is the OR of one-hot decodes of valid FIFO entries. It is registered state, combinationally decoded.

## Timing
- rf_*, wb_hold and div_ready are combinational from the inputs and registered state. No added latency on the WB path.
- A divider result accepted in cycle N writes no earlier than cycle N+1.
- Worst-case head wait is MAX_WAIT cycles plus the hold cycle.
- Reset state: FIFO empty, count 0, age 0, counters 0.
- Outputs after reset: div_ready=1, wb_hold=0, rf_we=0, div_pend_vec=0.
- Reset mid-operation discards buffered entries; nothing is written.

## Configuration
- RF_ARB_PERF_EN defined: perf_hold_cnt and perf_drop_cnt are 32-bit free-running counters that wrap at 2^32 and are cleared by reset.
- RF_ARB_PERF_EN undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- Idle divider, WB writes r5=0x1234 → rf_we=1, rf_waddr=5, rf_wdata=0x1234, same cycle, wb_hold=0.
- WB idle, divider offers r7=0xdead → next cycle rf_we=1, waddr=7; div_pend_vec bit7 high for exactly one cycle.
- Divider result enqueued, WB writes every cycle, MAX_WAIT=4 → after 4 WB writes, wb_hold=1 for one cycle with the divider entry written; perf_hold_cnt=1.
- Three back-to-back divider offers while WB is busy → div_ready drops to 0 on the third offer; both stored entries later retire in FIFO order.
- FIFO holds r9; WB writes r9 → WB data written, entry dropped, div_pend_vec bit9 cleared, perf_drop_cnt=1.
- Divider offers r0, and separately reset is asserted with 2 entries buffered → no r0 write; after reset FIFO is empty, div_ready=1, rf_we=0.

Source files
------------

// File: rtl/rf_wport_arb.sv
// rf_wport_arb
//
// Arbitrates the single register-file write port between the WB stage and
// the long-latency divider writeback path. Divider results wait in a
// 2-entry FIFO, and WB normally has priority. When a FIFO head has waited
// MAX_WAIT cycles, an aging counter forces a one-cycle WB hold so that the
// divider can write. A pending-register mask lets ID stall on registers
// whose divider result has not yet retired.
//
// Optional feature macro: RF_ARB_PERF_EN
//   defined   - perf_hold_cnt / perf_drop_cnt are free-running 32-bit counters
//   undefined - both ports read 0 and no counter registers exist
//
// Parameters:
//   MAX_WAIT      cycles a FIFO head may wait before WB is held (1..15)
//
// Ports:
//   clk           clock
//   resetn        synchronous active-low reset
//   wb_valid      WB stage holds a valid instruction
//   wb_rf_zip     {we, waddr[4:0], wdata[31:0]} from WB
//   wb_hold       port given to the divider this cycle; WB must not advance
//   div_valid     divider result offered
//   div_ready     FIFO can accept a result (not full)
//   div_waddr     divider destination register
//   div_wdata     divider result data
//   rf_we         register-file write enable
//   rf_waddr      register-file write address
//   rf_wdata      register-file write data
//   div_pend_vec  bit i set while a FIFO entry targets register i
//   perf_hold_cnt number of wb_hold cycles
//   perf_drop_cnt number of divider entries dropped by a WB write to the same register

module rf_wport_arb #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [37:0] wb_rf_zip,
  output logic        wb_hold,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [4:0]  div_waddr,
  input  logic [31:0] div_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] div_pend_vec,
  output logic [31:0] perf_hold_cnt,
  output logic [31:0] perf_drop_cnt
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_DIV
  } grant_t;

  localparam logic [3:0] MAX_AGE = 4'(MAX_WAIT);

  // FIFO storage and bookkeeping. The tail slot is derived as head + count.
  logic [4:0]  slot_addr [2];
  logic [31:0] slot_data [2];
  logic        head_ptr;
  logic [1:0]  count;
  logic [3:0]  age;

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_req;

  logic        head_valid;
  logic        second_valid;
  logic        second_ptr;
  logic [4:0]  head_addr;
  logic [4:0]  second_addr;
  logic [31:0] head_data;

  grant_t      grant;

  logic        head_waw;
  logic        second_waw;
  logic        kill_head;
  logic        keep_head;
  logic        keep_second;
  logic        enq;
  logic        head_next;
  logic        tail_slot;
  logic [1:0]  count_mid;
  logic [1:0]  count_next;
  logic [3:0]  age_next;

  assign wb_we    = wb_rf_zip[37];
  assign wb_waddr = wb_rf_zip[36:32];
  assign wb_wdata = wb_rf_zip[31:0];
  assign wb_req   = wb_valid && wb_we && (wb_waddr != 5'd0);

  assign head_valid   = (count != 2'd0);
  assign second_valid = (count == 2'd2);
  assign second_ptr   = ~head_ptr;
  assign head_addr    = slot_addr[head_ptr];
  assign head_data    = slot_data[head_ptr];
  assign second_addr  = slot_addr[second_ptr];

  // Readiness comes from the registered count only, so a full FIFO never
  // accepts in the same cycle that it dequeues. It is also withheld during
  // reset because an entry accepted then would be discarded immediately.
  assign div_ready = resetn && (count != 2'd2);

  // A write to r0 is accepted so that the divider is not stalled, but it is
  // never stored.
  assign enq = div_valid && div_ready && (div_waddr != 5'd0);

  // Grant selection. An aged head wins over WB. wb_hold is raised only when
  // WB actually had a write that lost the port. The grant is suppressed
  // while reset is asserted, so the buffered entries that reset discards
  // never reach the register file.
  always_comb begin
    grant   = GNT_NONE;
    wb_hold = 1'b0;
    if (resetn) begin
      if (head_valid && (age == MAX_AGE)) begin
        grant   = GNT_DIV;
        wb_hold = wb_req;
      end else if (wb_req) begin
        grant = GNT_WB;
      end else if (head_valid) begin
        grant = GNT_DIV;
      end
    end
  end

  // Write-port mux.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (grant)
      GNT_WB: begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      GNT_DIV: begin
        rf_we    = 1'b1;
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
      default: begin
      end
    endcase
  end

  // FIFO update. Entries are first removed, either by dequeue or by being
  // overwritten by a younger WB write to the same register. The survivors
  // stay in order. Then the new entry is appended after them. If only the
  // head is removed, the head pointer advances. If only the second entry is
  // removed, the tail pulls back.
  always_comb begin
    head_waw    = (grant == GNT_WB) && head_valid && (head_addr == wb_waddr);
    second_waw  = (grant == GNT_WB) && second_valid && (second_addr == wb_waddr);
    kill_head   = (grant == GNT_DIV) || head_waw;
    keep_head   = head_valid && !kill_head;
    keep_second = second_valid && !second_waw;
    count_mid   = {1'b0, keep_head} + {1'b0, keep_second};
    head_next   = (keep_head || !keep_second) ? head_ptr : second_ptr;
    tail_slot   = head_next ^ count_mid[0];
    count_next  = count_mid + {1'b0, enq};

    // Age tracks how long the current head has waited behind WB. It
    // restarts whenever the head changes or the FIFO drains.
    age_next = age;
    if (kill_head || (count_mid == 2'd0)) begin
      age_next = 4'd0;
    end else if ((grant == GNT_WB) && (age != MAX_AGE)) begin
      age_next = age + 4'd1;
    end
  end

  // FIFO control state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_ptr <= 1'b0;
      count    <= 2'd0;
      age      <= 4'd0;
    end else begin
      head_ptr <= head_next;
      count    <= count_next;
      age      <= age_next;
    end
  end

  // FIFO payload. Storage is not reset because count alone marks which
  // slots are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      slot_addr[tail_slot] <= div_waddr;
      slot_data[tail_slot] <= div_wdata;
    end
  end

  // Pending mask is the OR of one-hot decodes of the valid entries.
  always_comb begin
    div_pend_vec = 32'd0;
    if (head_valid) begin
      div_pend_vec[head_addr] = 1'b1;
    end
    if (second_valid) begin
      div_pend_vec[second_addr] = 1'b1;
    end
  end

`ifdef RF_ARB_PERF_EN
  logic [1:0]  drop_inc;
  logic [31:0] hold_cnt_q;
  logic [31:0] drop_cnt_q;

  assign drop_inc = {1'b0, head_waw} + {1'b0, second_waw};

  // Free-running counters that wrap at 2^32.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_cnt_q <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      if (wb_hold) begin
        hold_cnt_q <= hold_cnt_q + 32'd1;
      end
      drop_cnt_q <= drop_cnt_q + 32'(drop_inc);
    end
  end

  assign perf_hold_cnt = hold_cnt_q;
  assign perf_drop_cnt = drop_cnt_q;
`else
  assign perf_hold_cnt = 32'd0;
  assign perf_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb
//
// Directed bench for rf_wport_arb with MAX_WAIT=4. Each expected write is
// queued when it is driven: WB writes go to wb_q and accepted divider
// results go to div_q. A queued write is popped and compared when the step
// names its source as the writer. Inputs change 1 ns after the rising edge,
// and outputs are sampled on the falling edge. If RF_ARB_PERF_EN is
// defined, the expected counter values follow it.

module tb_rf_wport_arb;

  localparam int SRC_NONE = 0;
  localparam int SRC_WB   = 1;
  localparam int SRC_DIV  = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic [37:0] wb_rf_zip;
  logic        wb_hold;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_waddr;
  logic [31:0] div_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] div_pend_vec;
  logic [31:0] perf_hold_cnt;
  logic [31:0] perf_drop_cnt;

  int  checks;
  int  errors;
  wr_t wb_q[$];
  wr_t div_q[$];
  bit  wb_pushed;

  rf_wport_arb #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wb_valid      (wb_valid),
    .wb_rf_zip     (wb_rf_zip),
    .wb_hold       (wb_hold),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_waddr     (div_waddr),
    .div_wdata     (div_wdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .div_pend_vec  (div_pend_vec),
    .perf_hold_cnt (perf_hold_cnt),
    .perf_drop_cnt (perf_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] mkzip(input logic we, input logic [4:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge. Record a WB write
  // as expected if WB is asking for the port.
  task automatic applyStimulus(input logic wbv, input logic [37:0] zip, input logic dv,
                               input logic [4:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    wb_valid  = wbv;
    wb_rf_zip = zip;
    div_valid = dv;
    div_waddr = da;
    div_wdata = dd;
    wb_pushed = 1'b0;
    if (wbv && zip[37] && (zip[36:32] != 5'd0)) begin
      wb_q.push_back({zip[36:32], zip[31:0]});
      wb_pushed = 1'b1;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 38'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Sample on the falling edge. src names which queue must supply the write
  // seen this cycle. A WB request that did not win is taken back out of wb_q
  // because WB keeps it and presents it again.
  task automatic checkOutput(input string tag, input int src, input logic exp_hold,
                             input logic exp_ready, input logic [31:0] exp_pend);
    wr_t exp_wr;
    @(negedge clk);
    if ((src != SRC_WB) && wb_pushed) begin
      exp_wr = wb_q.pop_back();
    end
    wb_pushed = 1'b0;
    chk({tag, ".rf_we"}, 38'(rf_we), 38'(src != SRC_NONE));
    if (src == SRC_WB) begin
      chk({tag, ".wbq_avail"}, 38'(wb_q.size() != 0), 38'd1);
      if (wb_q.size() != 0) begin
        exp_wr = wb_q.pop_front();
        chk({tag, ".waddr"}, 38'(rf_waddr), 38'(exp_wr.addr));
        chk({tag, ".wdata"}, 38'(rf_wdata), 38'(exp_wr.data));
      end
    end else if (src == SRC_DIV) begin
      chk({tag, ".divq_avail"}, 38'(div_q.size() != 0), 38'd1);
      if (div_q.size() != 0) begin
        exp_wr = div_q.pop_front();
        chk({tag, ".waddr"}, 38'(rf_waddr), 38'(exp_wr.addr));
        chk({tag, ".wdata"}, 38'(rf_wdata), 38'(exp_wr.data));
      end
    end
    chk({tag, ".wb_hold"}, 38'(wb_hold), 38'(exp_hold));
    chk({tag, ".div_ready"}, 38'(div_ready), 38'(exp_ready));
    chk({tag, ".pend"}, 38'(div_pend_vec), 38'(exp_pend));
  endtask

  task automatic check_perf(input string tag, input int exp_hold_n, input int exp_drop_n);
    logic [31:0] eh;
    logic [31:0] ed;
`ifdef RF_ARB_PERF_EN
    eh = 32'(exp_hold_n);
    ed = 32'(exp_drop_n);
`else
    eh = 32'd0 & 32'(exp_hold_n);
    ed = 32'd0 & 32'(exp_drop_n);
`endif
    chk({tag, ".hold_cnt"}, 38'(perf_hold_cnt), 38'(eh));
    chk({tag, ".drop_cnt"}, 38'(perf_drop_cnt), 38'(ed));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wb_pushed = 1'b0;
    resetn    = 1'b0;
    wb_valid  = 1'b0;
    wb_rf_zip = 38'd0;
    div_valid = 1'b0;
    div_waddr = 5'd0;
    div_wdata = 32'd0;

    // Reset held: nothing written, port not offered to the divider.
    idle();
    idle();
    checkOutput("rst_hold", SRC_NONE, 1'b0, 1'b0, 32'd0);
    check_perf("rst_hold", 0, 0);
    idle();
    resetn = 1'b1;
    checkOutput("rst_release", SRC_NONE, 1'b0, 1'b1, 32'd0);

    // Plain WB writes, including the non-writing cases.
    applyStimulus(1'b1, mkzip(1'b1, 5'd5, 32'h1234), 1'b0, 5'd0, 32'd0);
    checkOutput("wb_r5", SRC_WB, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, mkzip(1'b0, 5'd6, 32'h5555), 1'b0, 5'd0, 32'd0);
    checkOutput("wb_we0", SRC_NONE, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, mkzip(1'b1, 5'd0, 32'h6666), 1'b0, 5'd0, 32'd0);
    checkOutput("wb_r0", SRC_NONE, 1'b0, 1'b1, 32'd0);

    // Divider result with WB idle writes one cycle later.
    applyStimulus(1'b0, 38'd0, 1'b1, 5'd7, 32'hdead);
    div_q.push_back({5'd7, 32'hdead});
    checkOutput("div_offer", SRC_NONE, 1'b0, 1'b1, 32'd0);
    idle();
    checkOutput("div_write", SRC_DIV, 1'b0, 1'b1, 32'h0000_0080);
    idle();
    checkOutput("div_after", SRC_NONE, 1'b0, 1'b1, 32'd0);

    // Aging: 4 WB writes win, then WB is held for the divider head.
    applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h11), 1'b1, 5'd3, 32'h333);
    div_q.push_back({5'd3, 32'h333});
    checkOutput("age_enq", SRC_WB, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h100 + 32'(k)), 1'b0, 5'd0, 32'd0);
      checkOutput($sformatf("age_wb%0d", k), SRC_WB, 1'b0, 1'b1, 32'h0000_0008);
    end
    applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h200), 1'b0, 5'd0, 32'd0);
    checkOutput("age_hold", SRC_DIV, 1'b1, 1'b1, 32'h0000_0008);
    applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h200), 1'b0, 5'd0, 32'd0);
    checkOutput("age_retry", SRC_WB, 1'b0, 1'b1, 32'd0);
    idle();
    checkOutput("age_idle", SRC_NONE, 1'b0, 1'b1, 32'd0);
    check_perf("age", 1, 0);

    // Three offers while WB is busy: the third sees a full FIFO.
    applyStimulus(1'b1, mkzip(1'b1, 5'd2, 32'h20), 1'b1, 5'd10, 32'hA0A0);
    div_q.push_back({5'd10, 32'hA0A0});
    checkOutput("full_1", SRC_WB, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, mkzip(1'b1, 5'd2, 32'h21), 1'b1, 5'd11, 32'hB1B1);
    div_q.push_back({5'd11, 32'hB1B1});
    checkOutput("full_2", SRC_WB, 1'b0, 1'b1, 32'h0000_0400);
    applyStimulus(1'b1, mkzip(1'b1, 5'd2, 32'h22), 1'b1, 5'd12, 32'hC2C2);
    checkOutput("full_3", SRC_WB, 1'b0, 1'b0, 32'h0000_0C00);
    applyStimulus(1'b0, 38'd0, 1'b1, 5'd12, 32'hC2C2);
    checkOutput("drain_1", SRC_DIV, 1'b0, 1'b0, 32'h0000_0C00);
    applyStimulus(1'b0, 38'd0, 1'b1, 5'd12, 32'hC2C2);
    div_q.push_back({5'd12, 32'hC2C2});
    checkOutput("drain_2", SRC_DIV, 1'b0, 1'b1, 32'h0000_0800);
    idle();
    checkOutput("drain_3", SRC_DIV, 1'b0, 1'b1, 32'h0000_1000);
    idle();
    checkOutput("drain_4", SRC_NONE, 1'b0, 1'b1, 32'd0);

    // WAW: WB write to r9 wins and drops the buffered r9 entry.
    applyStimulus(1'b0, 38'd0, 1'b1, 5'd9, 32'h999);
    checkOutput("waw_enq", SRC_NONE, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, mkzip(1'b1, 5'd9, 32'h4242), 1'b0, 5'd0, 32'd0);
    checkOutput("waw_wb", SRC_WB, 1'b0, 1'b1, 32'h0000_0200);
    idle();
    checkOutput("waw_after", SRC_NONE, 1'b0, 1'b1, 32'd0);
    check_perf("waw", 1, 1);

    // r0 divider result is accepted but never written.
    applyStimulus(1'b0, 38'd0, 1'b1, 5'd0, 32'hBAD);
    checkOutput("r0_offer", SRC_NONE, 1'b0, 1'b1, 32'd0);
    idle();
    checkOutput("r0_after", SRC_NONE, 1'b0, 1'b1, 32'd0);

    // Reset with two entries buffered discards them.
    applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h31), 1'b1, 5'd20, 32'h2020);
    checkOutput("mrst_1", SRC_WB, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, mkzip(1'b1, 5'd1, 32'h32), 1'b1, 5'd21, 32'h2121);
    checkOutput("mrst_2", SRC_WB, 1'b0, 1'b1, 32'h0010_0000);
    idle();
    resetn = 1'b0;
    checkOutput("mrst_assert", SRC_NONE, 1'b0, 1'b0, 32'h0030_0000);
    idle();
    resetn = 1'b1;
    checkOutput("mrst_release", SRC_NONE, 1'b0, 1'b1, 32'd0);
    check_perf("mrst", 0, 0);
    idle();
    checkOutput("mrst_idle", SRC_NONE, 1'b0, 1'b1, 32'd0);

    chk("final.wbq_empty", 38'(wb_q.size()), 38'd0);
    chk("final.divq_empty", 38'(div_q.size()), 38'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
